icache_refill: RTL and testbench
================================

// Module: icache_refill
// PURPOSE
//  Miss handler between the fetch stage's 4-line instruction cache and instruction memory.
//  On a cache miss it reads the 4 words of the missing 128b line, one word at a time, over a
//  req/valid handshake. It then writes the assembled line and its tag into the cache with a
//  single-cycle write pulse.
//  While busy it stalls fetch; fetch enable = !stall_fetch.
// PARAMETERS
//  MAX_WAIT  15  max cycles a single word request may wait for mem_valid before abort (1..255)
// PORTS
//  clk          in   1    clock; all state changes on posedge
//  rst          in   1    synchronous reset, active-high
//  miss         in   1    cache miss flag from fetch (combinational on its side)
//  miss_pc      in   5    PC that missed; line base = {miss_pc[4:2],2'b00}
//  mem_req      out  1    word read request to instruction memory
//  mem_addr     out  5    word address of current request
//  mem_rdata    in   32   returned word, valid when mem_valid=1
//  mem_valid    in   1    read data valid; sampled only while mem_req=1
//  fill_we      out  1    one-cycle cache line write strobe
//  fill_line    out  128  assembled line; word k in bits [32k+31:32k]
//  fill_tag     out  9    {valid=1, lru_cnt=3'b000, miss_pc[4:2], offset=2'b00}
//  stall_fetch  out  1    hold fetch PC/instruction register
//  refill_err   out  1    one-cycle pulse on timeout abort
//  refill_cnt   out  16   completed refills, saturating
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, mem_req=0, mem_addr=0, fill_we=0, fill_line=0,
//    fill_tag=0, refill_err=0, refill_cnt=0, word index k=0, wait counter=0.
//    stall_fetch=0 while rst=1.
//  - States: IDLE -> REQ -> FILL -> HOLD -> IDLE; REQ -> IDLE on timeout.
//  - IDLE: stall_fetch = miss (combinational, so fetch never advances past a miss).
//    If miss=1 at posedge, latch base={miss_pc[4:2],2'b00}, set k=0, and go to REQ.
//  - REQ: mem_req=1, mem_addr=base+k held stable until mem_valid seen.
//    On posedge with mem_valid=1, store mem_rdata in line word k, clear the wait counter,
//    and increment k. After word 3 is stored: mem_req=0, go to FILL.
//    Zero-wait memory (mem_valid high in the first cycle of a request) gives 1 word/cycle.
//  - Timeout: the wait counter counts cycles of the current word with mem_valid=0.
//    On the posedge where the count reaches MAX_WAIT: pulse refill_err for 1 cycle,
//    mem_req=0, go to IDLE. No fill_we in this case.
//  - FILL: fill_we=1 for exactly 1 cycle with stable fill_line/fill_tag.
//    refill_cnt+=1 unless already 16'hFFFF. Go to HOLD.
//  - HOLD: 1 cycle; stall_fetch=1; miss ignored, giving fetch one cycle to see the hit.
//    Go to IDLE.
//  - stall_fetch=1 in REQ, FILL and HOLD.
//  - fill_line and fill_tag keep their last values outside FILL. Only fill_we qualifies them.
//  - Latency with zero-wait memory: miss sampled at edge t; words captured at edges t+1..t+4;
//    fill_we high in the cycle after edge t+4; back in IDLE 2 cycles after the FILL edge.
//  - Ignored inputs:
//    - miss/miss_pc outside IDLE;
//    - mem_valid while mem_req=0 (no capture, no state change).
//  - Reset mid-refill: abort immediately. No fill_we, no refill_err, refill_cnt cleared.
//    mem_req=0 from the cycle after the reset edge.
//  - Simultaneous timeout edge and mem_valid=1: the data wins; the word is captured, no error.
//  - Address arithmetic is 5-bit; base+k never wraps because base[1:0]=0 and k<=3.
// TESTING
//  1. Zero-wait: miss=1, miss_pc=13, mem_valid=1 always.
//     -> mem_addr 12,13,14,15 on consecutive cycles; one fill_we;
//     fill_line={w15,w14,w13,w12}; fill_tag=9'h10C; refill_cnt=1.
//  2. Wait states: mem_valid asserted 3 cycles after each request, miss_pc=5'd2.
//     -> mem_addr held at each of 0..3 for 4 cycles; stall_fetch high throughout;
//     fill_we once; fill_tag=9'h100.
//  3. Timeout: MAX_WAIT=15, mem_valid stuck at 0 after word 1.
//     -> refill_err pulses once, 15 cycles into word 1; fill_we never asserted;
//     IDLE next cycle; refill_cnt unchanged.
//  4. Reset mid-refill: rst=1 one cycle after word 2 is captured.
//     -> all outputs at reset values after that edge; no fill_we.
//     A new miss afterwards starts again from word 0.
//  5. Back-to-back: miss held high across HOLD.
//     -> no request during FILL/HOLD; second refill begins after IDLE; refill_cnt=2.
//     Spurious mem_valid pulses in IDLE cause no capture.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache miss handler. It fetches the 4 words of a missing line over a
// req/valid handshake and writes the line and its tag into the cache with a 1-cycle strobe.
module icache_refill #(
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss,
  input  logic [4:0]   miss_pc,
  output logic         mem_req,
  output logic [4:0]   mem_addr,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_valid,
  output logic         fill_we,
  output logic [127:0] fill_line,
  output logic [8:0]   fill_tag,
  output logic         stall_fetch,
  output logic         refill_err,
  output logic [15:0]  refill_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_HOLD
  } state_t;

  // The timeout fires on the edge where the wait count would reach MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  line_idx;
  logic [1:0]  word_idx;
  logic [7:0]  wait_cnt;
  logic [95:0] word_buf;
  logic        start;
  logic        capture;
  logic        timeout;

  // The word offset of the missing PC does not matter; the whole line is fetched.
  logic unused_pc_bits;
  assign unused_pc_bits = ^miss_pc[1:0];

  assign mem_addr = {line_idx, word_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    fill_we     = 1'b0;
    stall_fetch = 1'b0;
    start       = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall_fetch = miss;
        if (miss) begin
          start     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req     = 1'b1;
        stall_fetch = 1'b1;
        // Returned data takes priority over a timeout that lands on the same edge.
        if (mem_valid) begin
          capture = 1'b1;
          if (word_idx == 2'd3) begin
            state_nxt = S_FILL;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        fill_we     = 1'b1;
        stall_fetch = 1'b1;
        state_nxt   = S_HOLD;
      end
      S_HOLD: begin
        stall_fetch = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Fetch runs freely while the handler is held in reset.
    if (rst) begin
      stall_fetch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_idx   <= 3'd0;
      word_idx   <= 2'd0;
      wait_cnt   <= 8'd0;
      fill_line  <= '0;
      fill_tag   <= '0;
      refill_err <= 1'b0;
      refill_cnt <= 16'd0;
    end else begin
      refill_err <= timeout;

      if (start) begin
        line_idx <= miss_pc[4:2];
        word_idx <= 2'd0;
        wait_cnt <= 8'd0;
      end

      if (capture) begin
        wait_cnt <= 8'd0;
        word_idx <= word_idx + 2'd1;
        if (word_idx == 2'd3) begin
          fill_line <= {mem_rdata, word_buf};
          fill_tag  <= {1'b1, 3'b000, line_idx, 2'b00};
        end
      end else if (timeout) begin
        wait_cnt <= 8'd0;
      end else if (state == S_REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (fill_we && (refill_cnt != 16'hFFFF)) begin
        refill_cnt <= refill_cnt + 16'd1;
      end
    end
  end

  // NOTE: the assembly buffer is deliberately not reset; each word is rewritten
  // before the line is published, so a reset value would never be observed.
  always_ff @(posedge clk) begin
    if (capture) begin
      case (word_idx)
        2'd0:    word_buf[31:0]  <= mem_rdata;
        2'd1:    word_buf[63:32] <= mem_rdata;
        2'd2:    word_buf[95:64] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: a latency-programmable memory responder feeds the DUT,
// expected fills are queued when a miss is issued and compared whenever fill_we pulses.
module tb_icache_refill;

  localparam int MAX_WAIT = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss;
  logic [4:0]   miss_pc;
  logic         mem_req;
  logic [4:0]   mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_valid;
  logic         fill_we;
  logic [127:0] fill_line;
  logic [8:0]   fill_tag;
  logic         stall_fetch;
  logic         refill_err;
  logic [15:0]  refill_cnt;

  icache_refill #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .miss        (miss),
    .miss_pc     (miss_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .fill_we     (fill_we),
    .fill_line   (fill_line),
    .fill_tag    (fill_tag),
    .stall_fetch (stall_fetch),
    .refill_err  (refill_err),
    .refill_cnt  (refill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] line;
    logic [8:0]   tag;
  } fill_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  fill_t       exp_q[$];
  logic [4:0]  addr_log[$];
  int          fill_seen = 0;
  int          err_seen  = 0;
  int          exp_cnt   = 0;

  int          lat         = 0;
  int          stuck_after = -1;
  bit          spurious    = 1'b0;
  logic [31:0] salt        = 32'd0;

  int          r_cnt;
  int          r_given;
  bit          r_gave;

  function automatic logic [31:0] mem_word(logic [4:0] a);
    return salt ^ (32'h1357_0000 + {27'd0, a} * 32'h0101_0011);
  endfunction

  function automatic fill_t expect_fill(logic [4:0] pc);
    logic [4:0] b;
    fill_t      f;
    b      = {pc[4:2], 2'b00};
    f.line = {mem_word(b + 5'd3), mem_word(b + 5'd2), mem_word(b + 5'd1), mem_word(b)};
    f.tag  = {1'b1, 3'b000, pc[4:2], 2'b00};
    return f;
  endfunction

  function automatic bit addr_log_is(logic [4:0] base, int per_word, int nwords);
    if (addr_log.size() != per_word * nwords) return 1'b0;
    for (int i = 0; i < addr_log.size(); i++) begin
      if (addr_log[i] !== base + 5'(i / per_word)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Memory model: answers each word after 'lat' idle cycles, optionally goes silent.
  initial begin : responder
    r_cnt     = 0;
    r_given   = 0;
    r_gave    = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (r_gave) r_cnt = 0;
        if (stuck_after >= 0 && r_given >= stuck_after) mem_valid = 1'b0;
        else mem_valid = (r_cnt >= lat);
        mem_rdata = mem_valid ? mem_word(mem_addr) : $urandom;
        r_gave = mem_valid;
        if (mem_valid) r_given++;
        r_cnt++;
      end else begin
        r_cnt     = 0;
        r_given   = 0;
        r_gave    = 1'b0;
        mem_valid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Scoreboard side: every fill strobe pops and compares one expected line.
  initial begin : monitor
    fill_t got;
    fill_t exp;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) addr_log.push_back(mem_addr);
      if (refill_err === 1'b1) err_seen++;
      if (fill_we === 1'b1) begin
        fill_seen++;
        n_checks++;
        got = {fill_line, fill_tag};
        if (exp_q.size() == 0) begin
          $display("FAIL fill_unexpected: got fill_we with line %h tag %h, required no fill",
                   fill_line, fill_tag);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)
            $display("FAIL fill_data: got line %h tag %h, required line %h tag %h",
                     got.line, got.tag, exp.line, exp.tag);
          else n_pass++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Issue one miss at a negedge and wait (bounded) for the fill strobe.
  task automatic run_refill(input logic [4:0] pc, input int max_cyc,
                            output int fill_cyc, output bit stall_ok);
    addr_log.delete();
    exp_q.push_back(expect_fill(pc));
    miss    = 1'b1;
    miss_pc = pc;
    @(negedge clk);
    miss     = 1'b0;
    miss_pc  = 5'($urandom);
    fill_cyc = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      #1;
      if (fill_we === 1'b1) begin
        fill_cyc = c;
        break;
      end
      if (stall_fetch !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  // Step through HOLD and back to IDLE after a fill was seen.
  task automatic check_tail(input string tag);
    @(negedge clk); #1;
    n_checks++;
    if (stall_fetch !== 1'b1 || fill_we !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL %s_hold: got stall %b we %b req %b, required 1 0 0",
               tag, stall_fetch, fill_we, mem_req);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (stall_fetch !== 1'b0 || refill_cnt !== 16'(exp_cnt))
      $display("FAIL %s_idle: got stall %b cnt %0d, required 0 %0d",
               tag, stall_fetch, refill_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    miss    = 1'b1;
    miss_pc = 5'd13;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 5'd0 || fill_we !== 1'b0)
      $display("FAIL reset_mem: got req %b addr %0d we %b, required 0 0 0", mem_req, mem_addr, fill_we);
    else n_pass++;
    n_checks++;
    if (fill_line !== 128'd0 || fill_tag !== 9'd0)
      $display("FAIL reset_fill: got line %h tag %h, required 0 0", fill_line, fill_tag);
    else n_pass++;
    n_checks++;
    if (refill_err !== 1'b0 || refill_cnt !== 16'd0)
      $display("FAIL reset_status: got err %b cnt %0d, required 0 0", refill_err, refill_cnt);
    else n_pass++;
    n_checks++;
    if (stall_fetch !== 1'b0)
      $display("FAIL reset_stall: got %b with miss=1 in reset, required 0", stall_fetch);
    else n_pass++;
    miss = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int fc;
    bit sok;
    lat  = 0;
    salt = 32'h0000_0000;
    run_refill(5'd13, 40, fc, sok);
    exp_cnt++;
    n_checks++;
    if (fc !== 5) $display("FAIL zw_latency: got fill after %0d cycles, required 5", fc);
    else n_pass++;
    n_checks++;
    if (!sok) $display("FAIL zw_stall: got stall_fetch low during refill, required high");
    else n_pass++;
    n_checks++;
    if (!addr_log_is(5'd12, 1, 4))
      $display("FAIL zw_addr: got %0d request cycles, required 12,13,14,15 one each", addr_log.size());
    else n_pass++;
    check_tail("zw");
  endtask

  task automatic test_wait_states();
    int fc;
    bit sok;
    lat  = 3;
    salt = 32'h5A5A_0F0F;
    run_refill(5'd2, 80, fc, sok);
    exp_cnt++;
    n_checks++;
    if (fc !== 17) $display("FAIL ws_latency: got fill after %0d cycles, required 17", fc);
    else n_pass++;
    n_checks++;
    if (!sok) $display("FAIL ws_stall: got stall_fetch low during refill, required high");
    else n_pass++;
    n_checks++;
    if (!addr_log_is(5'd0, 4, 4))
      $display("FAIL ws_addr: got %0d request cycles, required 0..3 four cycles each", addr_log.size());
    else n_pass++;
    check_tail("ws");
    lat = 0;
  endtask

  task automatic test_timeout();
    int err_cyc;
    int fills0;
    int errs0;
    int n21;
    lat         = 0;
    stuck_after = 1;
    salt        = 32'hDEAD_0001;
    fills0      = fill_seen;
    errs0       = err_seen;
    addr_log.delete();
    miss    = 1'b1;
    miss_pc = 5'd22;
    @(negedge clk);
    miss    = 1'b0;
    err_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (refill_err === 1'b1) begin
        err_cyc = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (err_cyc !== 17) $display("FAIL to_err_time: got refill_err at cycle %0d, required 17", err_cyc);
    else n_pass++;
    n_checks++;
    if (mem_req !== 1'b0 || stall_fetch !== 1'b0)
      $display("FAIL to_idle: got req %b stall %b after abort, required 0 0", mem_req, stall_fetch);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (refill_err !== 1'b0) $display("FAIL to_pulse: got refill_err %b one cycle later, required 0", refill_err);
    else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (fill_seen !== fills0 || err_seen - errs0 !== 1 || refill_cnt !== 16'(exp_cnt))
      $display("FAIL to_effects: got fills %0d errs %0d cnt %0d, required 0 1 %0d",
               fill_seen - fills0, err_seen - errs0, refill_cnt, exp_cnt);
    else n_pass++;
    n21 = 0;
    foreach (addr_log[i]) if (addr_log[i] === 5'd21) n21++;
    n_checks++;
    if (addr_log.size() !== 16 || addr_log[0] !== 5'd20 || n21 !== 15)
      $display("FAIL to_addr: got %0d requests with %0d at word 1, required 16 with 15", addr_log.size(), n21);
    else n_pass++;
    stuck_after = -1;
  endtask

  task automatic test_reset_mid();
    int fc;
    bit sok;
    int fills0;
    int errs0;
    lat    = 0;
    salt   = 32'h0BAD_F00D;
    fills0 = fill_seen;
    errs0  = err_seen;
    miss    = 1'b1;
    miss_pc = 5'd9;
    @(negedge clk);
    miss = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd11)
      $display("FAIL rm_before: got req %b addr %0d, required 1 11", mem_req, mem_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 5'd0 || fill_we !== 1'b0 || stall_fetch !== 1'b0)
      $display("FAIL rm_ctrl: got req %b addr %0d we %b stall %b, required 0 0 0 0",
               mem_req, mem_addr, fill_we, stall_fetch);
    else n_pass++;
    n_checks++;
    if (fill_line !== 128'd0 || fill_tag !== 9'd0 || refill_err !== 1'b0 || refill_cnt !== 16'd0)
      $display("FAIL rm_state: got line %h tag %h err %b cnt %0d, required all zero",
               fill_line, fill_tag, refill_err, refill_cnt);
    else n_pass++;
    rst     = 1'b0;
    exp_cnt = 0;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (fill_seen !== fills0 || err_seen !== errs0)
      $display("FAIL rm_quiet: got %0d fills %0d errs after reset, required 0 0",
               fill_seen - fills0, err_seen - errs0);
    else n_pass++;
    run_refill(5'd9, 40, fc, sok);
    exp_cnt++;
    n_checks++;
    if (fc !== 5 || !addr_log_is(5'd8, 1, 4))
      $display("FAIL rm_restart: got fill after %0d cycles with %0d requests, required 5 and 8..11", fc, addr_log.size());
    else n_pass++;
    check_tail("rm");
  endtask

  task automatic test_back_to_back();
    logic [12:1] req_tr;
    logic [12:1] we_tr;
    logic [12:1] stall_tr;
    logic [12:1] exp_req;
    logic [12:1] exp_we;
    int          fc;
    bit          sok;
    int          fills0;
    bit          req_seen;
    exp_req = 12'b011110001111;
    exp_we  = 12'b100000010000;
    lat     = 0;
    salt    = 32'h7777_1234;
    exp_q.push_back(expect_fill(5'd4));
    exp_q.push_back(expect_fill(5'd24));
    miss    = 1'b1;
    miss_pc = 5'd4;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      req_tr[c]   = mem_req;
      we_tr[c]    = fill_we;
      stall_tr[c] = stall_fetch;
      if (c == 2) miss_pc = 5'd24;
      if (c == 12) miss = 1'b0;
    end
    exp_cnt += 2;
    n_checks++;
    if (req_tr !== exp_req) $display("FAIL b2b_req: got trace %b, required %b", req_tr, exp_req);
    else n_pass++;
    n_checks++;
    if (we_tr !== exp_we) $display("FAIL b2b_we: got trace %b, required %b", we_tr, exp_we);
    else n_pass++;
    n_checks++;
    if (stall_tr !== 12'hFFF) $display("FAIL b2b_stall: got trace %b, required all ones", stall_tr);
    else n_pass++;
    check_tail("b2b");

    spurious = 1'b1;
    fills0   = fill_seen;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (mem_req !== 1'b0) req_seen = 1'b1;
    end
    spurious = 1'b0;
    n_checks++;
    if (req_seen || fill_seen !== fills0)
      $display("FAIL spur_idle: got req %b fills %0d with stray mem_valid, required 0 0", req_seen, fill_seen - fills0);
    else n_pass++;
    run_refill(5'd17, 40, fc, sok);
    exp_cnt++;
    n_checks++;
    if (fc !== 5 || !addr_log_is(5'd16, 1, 4))
      $display("FAIL spur_refill: got fill after %0d cycles with %0d requests, required 5 and 16..19", fc, addr_log.size());
    else n_pass++;
    check_tail("spur");
  endtask

  initial begin : main
    rst     = 1'b1;
    miss    = 1'b0;
    miss_pc = 5'd0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_drain: got %0d fills never seen, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
